harmonic_scheduler: RTL and testbench
=====================================

HARMONIC_SCHEDULER -- requirements
Module: harmonic_scheduler

Interface
REQ-001 SHALL provide parameters: DIV_BIT, default 11, multiplier width; HARM_BIT, default 7, harmonic index width; INC_BIT, default 16, phase-increment width; NYQ_LIMIT, default 2^(INC_BIT-1), maximum legal harmonic increment.
REQ-002 SHALL have ports, one per line:
  i_Clock  in  1  sole clock, rising edge.
  i_Reset_n  in  1  asynchronous, active-low reset.
  i_Sample_Start  in  1  one-cycle pulse starting one sample frame.
  i_Harm_Count  in  HARM_BIT  harmonics requested per frame; 0 is treated as 1.
  i_Base_Inc  in  INC_BIT  fundamental phase increment.
  o_SM_Restart  out  1  restart strobe to scale multiplier.
  o_SM_Start  out  1  step strobe to scale multiplier.
  i_SM_Ready  in  1  scale multiplier ready.
  i_SM_Mult  in  DIV_BIT  current scale multiplier level.
  o_Harm_Valid  out  1  harmonic descriptor valid.
  i_Harm_Ready  in  1  downstream accepts descriptor.
  o_Harm_Index  out  HARM_BIT  harmonic number, 0 = fundamental.
  o_Harm_Inc  out  INC_BIT  phase increment for this harmonic.
  o_Harm_Level  out  DIV_BIT  amplitude level for this harmonic.
  o_Frame_Done  out  1  one-cycle pulse at the end of a frame.
  o_Overrun  out  1  one-cycle pulse when i_Sample_Start arrives while busy.
REQ-003 SHALL drive all outputs from registers.

Function
REQ-004 SHALL implement the states IDLE, RESTART, EMIT, ISSUE, WAIT_MULT and DONE.
REQ-005 IDLE: on i_Sample_Start, SHALL latch i_Harm_Count and i_Base_Inc, clear the index, load the frequency accumulator with i_Base_Inc, and go to RESTART.
REQ-006 RESTART: SHALL hold o_SM_Restart high for exactly one cycle, then go to EMIT.
REQ-007 EMIT: SHALL assert o_Harm_Valid with o_Harm_Index, o_Harm_Inc (the accumulator) and o_Harm_Level (i_SM_Mult), all held stable until i_Harm_Ready is sampled high.
REQ-008 On the accept cycle, the scheduler SHALL go to DONE if any termination condition holds; otherwise it SHALL go to ISSUE.
REQ-009 The termination conditions SHALL be:
  - index+1 >= the latched count;
  - accumulator + latched base > NYQ_LIMIT, evaluated in INC_BIT+1 bits with no wrap;
  - i_SM_Mult == 0.
REQ-010 ISSUE: SHALL pulse o_SM_Start for one cycle, increment the index, add the latched base to the accumulator, and go to WAIT_MULT.
REQ-011 WAIT_MULT: SHALL set a busy-seen flag when i_SM_Ready is sampled low, and SHALL go to EMIT on the first cycle in which i_SM_Ready is high after the flag is set.
REQ-012 DONE: SHALL pulse o_Frame_Done for one cycle and return to IDLE.
REQ-013 Latency from i_Sample_Start to the first o_Harm_Valid SHALL be 2 cycles.
REQ-014 Each subsequent harmonic SHALL follow its predecessor's accept by at most 4 cycles when the multiplier has 2-cycle latency.
REQ-015 i_Sample_Start outside IDLE SHALL be ignored, and SHALL produce an o_Overrun pulse in the following cycle.
REQ-016 When i_Sample_Start and DONE coincide, the scheduler SHALL ignore the start and pulse o_Overrun.
REQ-017 Frame inputs SHALL be sampled only in IDLE; changes mid-frame SHALL have no effect until the next frame.
REQ-018 The index SHALL never wrap; termination fires no later than index = 2^HARM_BIT-1.

Reset
REQ-019 While i_Reset_n is low, the block SHALL enter IDLE asynchronously, with every output, the index, the accumulator and the busy-seen flag at 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no o_Frame_Done pulse.
REQ-021 The first frame after reset release SHALL assert o_SM_Restart before any o_SM_Start.

Structure
REQ-022 A shared package SHALL hold the DIV_BIT, HARM_BIT, INC_BIT and NYQ_LIMIT defaults and the state-encoding constants (3 bits).
REQ-023 The block SHALL contain no sub-module.
REQ-024 The scale multiplier SHALL be instantiated beside this block by the parent, not inside it.

Verification
REQ-025 Count=4, Base=0x0400, multiplier initial 1000, scale 100, Ready always high -> 4 descriptors: (0,0x0400,1000), (1,0x0800,900), (2,0x0C00,800), (3,0x1000,700), then one o_Frame_Done pulse.
REQ-026 Base=0x3000, count=10 -> indexes 0 and 1 only: 0x9000 > 0x8000 terminates after index 1, with no increment wrap.
REQ-027 Initial 250, scale 100, count=8 -> levels 250, 150, 50, 0; the frame ends after the level-0 descriptor.
REQ-028 Hold i_Harm_Ready low for 5 cycles at index 1 -> o_Harm_Valid and all fields stable throughout; no o_SM_Start until accept.
REQ-029 Second i_Sample_Start at index 2 -> one o_Overrun pulse; the frame completes unchanged.
REQ-030 Assert i_Reset_n low during WAIT_MULT -> all outputs 0 immediately; the next start issues o_SM_Restart first.

Source files
------------

// File: rtl/harmonic_scheduler_pkg.sv
// ============================================================================
// harmonic_scheduler_pkg : shared widths, Nyquist default, state encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package harmonic_scheduler_pkg;

  localparam int c_DIV_BIT  = 11;
  localparam int c_HARM_BIT = 7;
  localparam int c_INC_BIT  = 16;

  // Largest legal phase increment is half the phase wheel.
  function automatic int nyq_default(input int inc_bit);
    return 2 ** (inc_bit - 1);
  endfunction

  localparam int c_NYQ_LIMIT = nyq_default(c_INC_BIT);

  localparam int c_STATE_W = 3;
  localparam logic [2:0] c_S_IDLE      = 3'd0;
  localparam logic [2:0] c_S_RESTART   = 3'd1;
  localparam logic [2:0] c_S_EMIT      = 3'd2;
  localparam logic [2:0] c_S_ISSUE     = 3'd3;
  localparam logic [2:0] c_S_WAIT_MULT = 3'd4;
  localparam logic [2:0] c_S_DONE      = 3'd5;

endpackage

`default_nettype wire

// File: rtl/harmonic_scheduler.sv
// ============================================================================
// harmonic_scheduler : walks one harmonic series per sample frame, pacing a
// neighbouring scale multiplier and emitting (index, increment, level) tuples.
// Revision: 1.0
// ============================================================================
`default_nettype none

module harmonic_scheduler
  import harmonic_scheduler_pkg::*;
#(
  parameter int DIV_BIT   = c_DIV_BIT,
  parameter int HARM_BIT  = c_HARM_BIT,
  parameter int INC_BIT   = c_INC_BIT,
  parameter int NYQ_LIMIT = nyq_default(INC_BIT)
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_Sample_Start,
  input  logic [HARM_BIT-1:0] i_Harm_Count,
  input  logic [INC_BIT-1:0]  i_Base_Inc,
  output logic                o_SM_Restart,
  output logic                o_SM_Start,
  input  logic                i_SM_Ready,
  input  logic [DIV_BIT-1:0]  i_SM_Mult,
  output logic                o_Harm_Valid,
  input  logic                i_Harm_Ready,
  output logic [HARM_BIT-1:0] o_Harm_Index,
  output logic [INC_BIT-1:0]  o_Harm_Inc,
  output logic [DIV_BIT-1:0]  o_Harm_Level,
  output logic                o_Frame_Done,
  output logic                o_Overrun
);

  localparam logic [INC_BIT:0] c_NYQ = (INC_BIT+1)'(NYQ_LIMIT);

  logic [c_STATE_W-1:0] state_q,      state_d;
  logic [HARM_BIT-1:0]  count_q,      count_d;
  logic [INC_BIT-1:0]   base_q,       base_d;
  logic [INC_BIT-1:0]   acc_q,        acc_d;
  logic [HARM_BIT-1:0]  index_q,      index_d;
  logic [DIV_BIT-1:0]   level_q,      level_d;
  logic                 busy_seen_q,  busy_seen_d;
  logic                 valid_q,      valid_d;
  logic                 sm_restart_q, sm_restart_d;
  logic                 sm_start_q,   sm_start_d;
  logic                 done_q,       done_d;
  logic                 overrun_q,    overrun_d;

  logic [HARM_BIT:0] w_idx_next;
  logic [INC_BIT:0]  w_acc_sum;
  logic              w_terminate;

  // Widened by one bit so neither the index nor the increment can wrap.
  assign w_idx_next  = {1'b0, index_q} + {{HARM_BIT{1'b0}}, 1'b1};
  assign w_acc_sum   = {1'b0, acc_q} + {1'b0, base_q};
  assign w_terminate = (w_idx_next >= {1'b0, count_q}) ||
                       (w_acc_sum > c_NYQ) ||
                       (i_SM_Mult == '0);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    base_d       = base_q;
    acc_d        = acc_q;
    index_d      = index_q;
    level_d      = level_q;
    busy_seen_d  = busy_seen_q;
    valid_d      = valid_q;
    sm_restart_d = 1'b0;
    sm_start_d   = 1'b0;
    done_d       = 1'b0;
    overrun_d    = i_Sample_Start && (state_q != c_S_IDLE);

    case (state_q)
      c_S_IDLE: begin
        if (i_Sample_Start) begin
          count_d      = (i_Harm_Count == '0) ? HARM_BIT'(1) : i_Harm_Count;
          base_d       = i_Base_Inc;
          acc_d        = i_Base_Inc;
          index_d      = '0;
          sm_restart_d = 1'b1;
          state_d      = c_S_RESTART;
        end
      end
      c_S_RESTART: begin
        valid_d = 1'b1;
        level_d = i_SM_Mult;
        state_d = c_S_EMIT;
      end
      c_S_EMIT: begin
        if (i_Harm_Ready) begin
          valid_d = 1'b0;
          if (w_terminate) begin
            done_d  = 1'b1;
            state_d = c_S_DONE;
          end else begin
            sm_start_d = 1'b1;
            state_d    = c_S_ISSUE;
          end
        end
      end
      c_S_ISSUE: begin
        index_d     = index_q + HARM_BIT'(1);
        acc_d       = acc_q + base_q;
        busy_seen_d = 1'b0;
        state_d     = c_S_WAIT_MULT;
      end
      c_S_WAIT_MULT: begin
        // Ready is only trusted once the multiplier has shown it went busy.
        if (!i_SM_Ready) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          busy_seen_d = 1'b0;
          valid_d     = 1'b1;
          level_d     = i_SM_Mult;
          state_d     = c_S_EMIT;
        end
      end
      c_S_DONE: begin
        state_d = c_S_IDLE;
      end
      default: begin
        state_d = c_S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= c_S_IDLE;
      count_q      <= '0;
      base_q       <= '0;
      acc_q        <= '0;
      index_q      <= '0;
      level_q      <= '0;
      busy_seen_q  <= 1'b0;
      valid_q      <= 1'b0;
      sm_restart_q <= 1'b0;
      sm_start_q   <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      base_q       <= base_d;
      acc_q        <= acc_d;
      index_q      <= index_d;
      level_q      <= level_d;
      busy_seen_q  <= busy_seen_d;
      valid_q      <= valid_d;
      sm_restart_q <= sm_restart_d;
      sm_start_q   <= sm_start_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_SM_Restart = sm_restart_q;
  assign o_SM_Start   = sm_start_q;
  assign o_Harm_Valid = valid_q;
  assign o_Harm_Index = index_q;
  assign o_Harm_Inc   = acc_q;
  assign o_Harm_Level = level_q;
  assign o_Frame_Done = done_q;
  assign o_Overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_harmonic_scheduler.sv
// ============================================================================
// tb_harmonic_scheduler : scoreboard bench with a 2-cycle scale multiplier model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_harmonic_scheduler;
  import harmonic_scheduler_pkg::*;

  localparam int DIV_BIT  = 11;
  localparam int HARM_BIT = 7;
  localparam int INC_BIT  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sample_start;
  logic [HARM_BIT-1:0] harm_count;
  logic [INC_BIT-1:0]  base_inc;
  logic                sm_restart, sm_start, sm_ready;
  logic [DIV_BIT-1:0]  sm_mult;
  logic                harm_valid, harm_ready;
  logic [HARM_BIT-1:0] harm_index;
  logic [INC_BIT-1:0]  harm_inc;
  logic [DIV_BIT-1:0]  harm_level;
  logic                frame_done, overrun;

  always #5 clk = ~clk;

  harmonic_scheduler dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Sample_Start (sample_start),
    .i_Harm_Count   (harm_count),
    .i_Base_Inc     (base_inc),
    .o_SM_Restart   (sm_restart),
    .o_SM_Start     (sm_start),
    .i_SM_Ready     (sm_ready),
    .i_SM_Mult      (sm_mult),
    .o_Harm_Valid   (harm_valid),
    .i_Harm_Ready   (harm_ready),
    .o_Harm_Index   (harm_index),
    .o_Harm_Inc     (harm_inc),
    .o_Harm_Level   (harm_level),
    .o_Frame_Done   (frame_done),
    .o_Overrun      (overrun)
  );

  // Scale multiplier: restart loads the initial level (visible at once),
  // each step is busy for two cycles and then subtracts the scale, floored at 0.
  logic [DIV_BIT-1:0] mult_q, init_lvl, scale_lvl;
  logic [1:0]         busy_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_q   <= '0;
      busy_cnt <= '0;
    end else if (sm_restart) begin
      mult_q   <= init_lvl;
      busy_cnt <= '0;
    end else if (sm_start) begin
      busy_cnt <= 2'd2;
    end else if (busy_cnt == 2'd1) begin
      mult_q   <= (mult_q > scale_lvl) ? mult_q - scale_lvl : '0;
      busy_cnt <= '0;
    end else if (busy_cnt != 2'd0) begin
      busy_cnt <= busy_cnt - 2'd1;
    end
  end

  assign sm_ready = (busy_cnt == 2'd0);
  assign sm_mult  = sm_restart ? init_lvl : mult_q;

  typedef struct packed {
    logic [HARM_BIT-1:0] idx;
    logic [INC_BIT-1:0]  inc;
    logic [DIV_BIT-1:0]  lvl;
  } desc_t;

  desc_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    done_cnt = 0, overrun_cnt = 0, restart_cnt = 0;
  int    stall_viol = 0, order_viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int inc, input int lvl);
    desc_t d;
    d.idx = HARM_BIT'(idx);
    d.inc = INC_BIT'(inc);
    d.lvl = DIV_BIT'(lvl);
    exp_q.push_back(d);
  endtask

  // Monitor: pops the scoreboard on every accepted descriptor and tracks pulses.
  logic  prev_stall = 1'b0;
  desc_t prev_desc;
  logic  seen_restart = 1'b0;

  always @(negedge clk) begin
    desc_t e;
    if (!rst_n) begin
      prev_stall   = 1'b0;
      seen_restart = 1'b0;
    end else begin
      if (sm_restart) begin
        seen_restart = 1'b1;
        restart_cnt++;
      end
      if (sm_start && !seen_restart) order_viol++;
      if (frame_done) done_cnt++;
      if (overrun) overrun_cnt++;
      if (prev_stall && (!harm_valid || {harm_index, harm_inc, harm_level} != prev_desc))
        stall_viol++;
      if (harm_valid && sm_start) stall_viol++;
      prev_stall = harm_valid && !harm_ready;
      prev_desc  = {harm_index, harm_inc, harm_level};
      if (harm_valid && harm_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_desc: got idx=%0d inc=%0h lvl=%0d, expected none",
                   harm_index, harm_inc, harm_level);
        end else begin
          e = exp_q.pop_front();
          check("desc_index", 64'(harm_index), 64'(e.idx));
          check("desc_inc",   64'(harm_inc),   64'(e.inc));
          check("desc_level", 64'(harm_level), 64'(e.lvl));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sm_restart"}, 64'(sm_restart), 0);
    check({tag, "_sm_start"},   64'(sm_start),   0);
    check({tag, "_valid"},      64'(harm_valid), 0);
    check({tag, "_index"},      64'(harm_index), 0);
    check({tag, "_inc"},        64'(harm_inc),   0);
    check({tag, "_level"},      64'(harm_level), 0);
    check({tag, "_frame_done"}, 64'(frame_done), 0);
    check({tag, "_overrun"},    64'(overrun),    0);
  endtask

  task automatic start_frame(input int cnt, input int base, input int init, input int scale);
    init_lvl     = DIV_BIT'(init);
    scale_lvl    = DIV_BIT'(scale);
    harm_count   = HARM_BIT'(cnt);
    base_inc     = INC_BIT'(base);
    sample_start = 1'b1;
    @(posedge clk); #1;
    sample_start = 1'b0;
    check("restart_cycle_restart", 64'(sm_restart), 1);
    check("restart_cycle_valid",   64'(harm_valid), 0);
    // Mid-frame changes must be ignored.
    harm_count = '1;
    base_inc   = '1;
    @(posedge clk); #1;
    check("first_valid_latency", 64'(harm_valid), 1);
  endtask

  // sel 0: step strobe, 1: descriptor valid, 2: descriptor valid at index 2
  task automatic wait_until(input int sel, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      case (sel)
        0:       hit = sm_start;
        1:       hit = harm_valid;
        default: hit = harm_valid && (harm_index == HARM_BIT'(2));
      endcase
    end
    if (!hit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no event, expected one within 100 cycles", name);
    end
  endtask

  task automatic wait_done(input bit poke_start);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        got = 1'b1;
        if (poke_start) begin
          sample_start = 1'b1;
          @(posedge clk); #1;
          sample_start = 1'b0;
        end
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_done_timeout: got no pulse, expected one within 400 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 0);
  endtask

  int d0, o0, r0;

  initial begin
    rst_n        = 1'b0;
    sample_start = 1'b0;
    harm_ready   = 1'b1;
    harm_count   = '0;
    base_inc     = '0;
    init_lvl     = '0;
    scale_lvl    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic four-harmonic frame
    d0 = done_cnt; o0 = overrun_cnt;
    push(0, 'h0400, 1000); push(1, 'h0800, 900); push(2, 'h0C00, 800); push(3, 'h1000, 700);
    start_frame(4, 'h0400, 1000, 100);
    wait_done(1'b0);
    check("t1_done_pulses", 64'(done_cnt - d0), 1);
    check("t1_overruns",    64'(overrun_cnt - o0), 0);

    // Nyquist termination: 0x6000 + 0x3000 exceeds 0x8000
    d0 = done_cnt;
    push(0, 'h3000, 1000); push(1, 'h6000, 900);
    start_frame(10, 'h3000, 1000, 100);
    wait_done(1'b0);
    check("t2_done_pulses", 64'(done_cnt - d0), 1);

    // Level reaching zero ends the frame
    d0 = done_cnt;
    push(0, 'h0100, 250); push(1, 'h0200, 150); push(2, 'h0300, 50); push(3, 'h0400, 0);
    start_frame(8, 'h0100, 250, 100);
    wait_done(1'b0);
    check("t3_done_pulses", 64'(done_cnt - d0), 1);

    // Downstream stall on index 1
    d0 = done_cnt;
    push(0, 'h0400, 1000); push(1, 'h0800, 900); push(2, 'h0C00, 800);
    start_frame(3, 'h0400, 1000, 100);
    wait_until(0, "t4_first_step");
    harm_ready = 1'b0;
    wait_until(1, "t4_index1_valid");
    for (int k = 0; k < 5; k++) begin
      check("t4_stall_valid",    64'(harm_valid), 1);
      check("t4_stall_index",    64'(harm_index), 1);
      check("t4_stall_no_start", 64'(sm_start),   0);
      @(posedge clk); #1;
    end
    harm_ready = 1'b1;
    wait_done(1'b0);
    check("t4_done_pulses", 64'(done_cnt - d0), 1);

    // Extra start while at index 2
    d0 = done_cnt; o0 = overrun_cnt;
    push(0, 'h0400, 1000); push(1, 'h0800, 900); push(2, 'h0C00, 800); push(3, 'h1000, 700);
    start_frame(4, 'h0400, 1000, 100);
    wait_until(2, "t5_index2_valid");
    sample_start = 1'b1;
    @(posedge clk); #1;
    sample_start = 1'b0;
    wait_done(1'b0);
    check("t5_overruns",    64'(overrun_cnt - o0), 1);
    check("t5_done_pulses", 64'(done_cnt - d0), 1);

    // Count 0 acts as 1; a start landing on DONE is rejected
    d0 = done_cnt; o0 = overrun_cnt; r0 = restart_cnt;
    push(0, 'h0500, 600);
    start_frame(0, 'h0500, 600, 100);
    wait_done(1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_overruns",    64'(overrun_cnt - o0), 1);
    check("t6_done_pulses", 64'(done_cnt - d0), 1);
    check("t6_restarts",    64'(restart_cnt - r0), 1);
    check("t6_idle_valid",  64'(harm_valid), 0);

    // Reset while waiting on the multiplier
    d0 = done_cnt;
    push(0, 'h0400, 1000);
    start_frame(4, 'h0400, 1000, 100);
    wait_until(0, "t7_first_step");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t7_no_done_after_abort", 64'(done_cnt - d0), 0);
    r0 = restart_cnt;
    push(0, 'h0200, 500); push(1, 'h0400, 400);
    start_frame(2, 'h0200, 500, 100);
    wait_done(1'b0);
    check("t7_restarts", 64'(restart_cnt - r0), 1);

    check("stall_violations",         64'(stall_viol), 0);
    check("restart_order_violations", 64'(order_viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
